// File: rtl/boundary_generator.sv
// River left-bank generator: preloads ROWS straight rows, then one LFSR random-walk row per scroll tick (BOUNDARY_BRIDGE_EN adds straight bridges).
// Latency: scroll_tick in IDLE at cycle t -> shift_valid at t+2; up to 3 ticks buffered while busy.
// Backpressure: shift_valid and boundary_out hold until shift_ready; ticks beyond the buffer set sticky tick_overflow.
module boundary_generator #(
    parameter int          WIDTH        = 10,
    parameter int          ROWS         = 240,
    parameter int          START_POS    = 200,
    parameter int          MIN_POS      = 40,
    parameter int          MAX_POS      = 360,
    parameter int          STEP         = 2,
    parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scroll_tick,
    input  logic             seed_load,
    input  logic [15:0]      seed,
    output logic [WIDTH-1:0] boundary_out,
    output logic             shift_valid,
    input  logic             shift_ready,
    output logic             init_done,
    output logic             tick_overflow
);

    localparam int CNT_W = $clog2(ROWS + 1);
    localparam logic signed [WIDTH:0] STEP_S = (WIDTH+1)'(STEP);
    localparam logic signed [WIDTH:0] MIN_S  = (WIDTH+1)'(MIN_POS);
    localparam logic signed [WIDTH:0] MAX_S  = (WIDTH+1)'(MAX_POS);
    localparam logic [1:0] DIR_ZERO = 2'b00;
    localparam logic [1:0] DIR_POS  = 2'b01;
    localparam logic [1:0] DIR_NEG  = 2'b11;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_GEN, ST_PUSH} state_t;

    state_t            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [WIDTH-1:0]  cur_pos_q, cur_pos_d;
    logic [1:0]        dir_q, dir_d;
    logic [4:0]        run_cnt_q, run_cnt_d;
    logic [1:0]        pending_q, pending_d;
    logic [CNT_W-1:0]  init_cnt_q, init_cnt_d;
    logic              valid_q, valid_d;
    logic              init_done_q, init_done_d;
    logic              overflow_q, overflow_d;
`ifdef BOUNDARY_BRIDGE_EN
    logic [5:0]        row_cnt_q, row_cnt_d;
`endif

    logic [15:0]       lfsr_adv;
    logic [1:0]        dir_gen;
    logic [4:0]        run_gen;
    logic signed [WIDTH:0] delta;
    logic signed [WIDTH:0] next_pos;
    logic [WIDTH-1:0]  pos_gen;
    logic [1:0]        dir_fin;

    // Fibonacci LFSR, taps 16,14,13,11, shifting left with feedback into bit 0.
    assign lfsr_adv = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_comb begin
        dir_gen = dir_q;
        run_gen = run_cnt_q - 5'd1;
        if (run_cnt_q == 5'd0) begin
            run_gen = {1'b0, lfsr_adv[3:0]} + 5'd4;
            case (lfsr_adv[5:4])
                2'b01:   dir_gen = DIR_POS;
                2'b10:   dir_gen = DIR_NEG;
                default: dir_gen = DIR_ZERO;
            endcase
        end
`ifdef BOUNDARY_BRIDGE_EN
        if (row_cnt_q == 6'd63) begin
            dir_gen = DIR_ZERO;
            run_gen = 5'd15;
        end
`endif
        case (dir_gen)
            DIR_POS: delta = STEP_S;
            DIR_NEG: delta = -STEP_S;
            default: delta = '0;
        endcase
        next_pos = $signed({1'b0, cur_pos_q}) + delta;
        pos_gen  = next_pos[WIDTH-1:0];
        dir_fin  = dir_gen;
        if (next_pos > MAX_S) begin
            pos_gen = WIDTH'(MAX_POS);
            dir_fin = DIR_NEG;
        end else if (next_pos < MIN_S) begin
            pos_gen = WIDTH'(MIN_POS);
            dir_fin = DIR_POS;
        end
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        cur_pos_d   = cur_pos_q;
        dir_d       = dir_q;
        run_cnt_d   = run_cnt_q;
        pending_d   = pending_q;
        init_cnt_d  = init_cnt_q;
        valid_d     = valid_q;
        init_done_d = init_done_q;
        overflow_d  = overflow_q;
`ifdef BOUNDARY_BRIDGE_EN
        row_cnt_d   = row_cnt_q;
`endif
        // Ticks while busy are queued; ticks during preload are simply dropped.
        if (scroll_tick && (state_q == ST_GEN || state_q == ST_PUSH)) begin
            if (pending_q == 2'd3) overflow_d = 1'b1;
            else                   pending_d  = pending_q + 2'd1;
        end
        case (state_q)
            ST_INIT: begin
                valid_d = 1'b1;
                if (valid_q && shift_ready) begin
                    init_cnt_d = init_cnt_q + CNT_W'(1);
                    if (init_cnt_q == CNT_W'(ROWS - 1)) begin
                        valid_d     = 1'b0;
                        init_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (seed_load) lfsr_d = (seed == 16'd0) ? SEED_DEFAULT : seed;
                if (pending_q != 2'd0) begin
                    state_d = ST_GEN;
                    if (!scroll_tick) pending_d = pending_q - 2'd1;
                end else if (scroll_tick) begin
                    state_d = ST_GEN;
                end
            end
            ST_GEN: begin
                lfsr_d    = lfsr_adv;
                run_cnt_d = run_gen;
                dir_d     = dir_fin;
                cur_pos_d = pos_gen;
                valid_d   = 1'b1;
                state_d   = ST_PUSH;
`ifdef BOUNDARY_BRIDGE_EN
                row_cnt_d = row_cnt_q + 6'd1;
`endif
            end
            default: begin
                if (shift_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            lfsr_q      <= SEED_DEFAULT;
            cur_pos_q   <= WIDTH'(START_POS);
            dir_q       <= DIR_ZERO;
            run_cnt_q   <= '0;
            pending_q   <= '0;
            init_cnt_q  <= '0;
            valid_q     <= 1'b0;
            init_done_q <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef BOUNDARY_BRIDGE_EN
            row_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cur_pos_q   <= cur_pos_d;
            dir_q       <= dir_d;
            run_cnt_q   <= run_cnt_d;
            pending_q   <= pending_d;
            init_cnt_q  <= init_cnt_d;
            valid_q     <= valid_d;
            init_done_q <= init_done_d;
            overflow_q  <= overflow_d;
`ifdef BOUNDARY_BRIDGE_EN
            row_cnt_q   <= row_cnt_d;
`endif
        end
    end

    assign boundary_out  = cur_pos_q;
    assign shift_valid   = valid_q;
    assign init_done     = init_done_q;
    assign tick_overflow = overflow_q;

endmodule

// File: tb/tb_boundary_generator.sv
// Directed bench for boundary_generator: preload, latency, stall, tick backlog, long walk, mid-preload reset.
module tb_boundary_generator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scroll_tick;
    logic        seed_load;
    logic [15:0] seed;
    logic [9:0]  boundary_out;
    logic        shift_valid;
    logic        shift_ready;
    logic        init_done;
    logic        tick_overflow;

    always #5 clk = ~clk;

    boundary_generator dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .scroll_tick   (scroll_tick),
        .seed_load     (seed_load),
        .seed          (seed),
        .boundary_out  (boundary_out),
        .shift_valid   (shift_valid),
        .shift_ready   (shift_ready),
        .init_done     (init_done),
        .tick_overflow (tick_overflow)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         hs_cnt      = 0;
    int         preload_bad = 0;
    int         range_err   = 0;
    int         bp_err      = 0;
    int         step_bad    = 0;
    int         stable_err  = 0;
    logic       samp_valid  = 1'b0;
    logic [9:0] samp_out    = '0;
    logic [9:0] last_hs_val = '0;
    logic [9:0] prev_hs_val = '0;
    logic       have_prev   = 1'b0;
    logic       prev_stall  = 1'b0;
    logic [9:0] prev_out    = '0;
    logic [9:0] held;
    logic       v0, v1, v2;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One clock cycle: observe at the falling edge, return just after the rising edge.
    task automatic cyc();
        int diff;
        @(negedge clk);
        samp_valid = shift_valid;
        samp_out   = boundary_out;
        if (boundary_out < 10'd40 || boundary_out > 10'd360) range_err++;
        if (prev_stall && rst_n && (!shift_valid || boundary_out != prev_out)) bp_err++;
        prev_stall = rst_n && shift_valid && !shift_ready;
        prev_out   = boundary_out;
        if (rst_n && shift_valid && shift_ready) begin
            hs_cnt++;
            last_hs_val = boundary_out;
            if (!init_done) begin
                if (boundary_out != 10'd200) preload_bad++;
            end else if (have_prev) begin
                diff = int'(boundary_out) - int'(prev_hs_val);
                if (diff != 0 && diff != 2 && diff != -2) step_bad++;
            end
            prev_hs_val = boundary_out;
            have_prev   = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        scroll_tick = 1'b0;
        seed_load   = 1'b0;
        seed        = 16'h0000;
        shift_ready = 1'b1;
        #12;
        check("rst_valid", shift_valid, 0);
        check("rst_init_done", init_done, 0);
        check("rst_overflow", tick_overflow, 0);
        check("rst_out", boundary_out, 200);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Preload; a few ticks thrown in must be ignored.
        hs_cnt = 0;
        for (int i = 0; i < 400 && !init_done; i++) begin
            scroll_tick = (i % 50 == 7);
            cyc();
        end
        scroll_tick = 1'b0;
        check("preload_done", init_done, 1);
        check("preload_count", hs_cnt, 240);
        check("preload_values", preload_bad, 0);
        hs_cnt = 0;
        repeat (10) cyc();
        check("idle_no_push", hs_cnt, 0);
        check("init_tick_no_ovf", tick_overflow, 0);

        // Tick-to-valid latency.
        scroll_tick = 1'b1; cyc(); v0 = samp_valid;
        scroll_tick = 1'b0; cyc(); v1 = samp_valid;
        cyc(); v2 = samp_valid;
        check("lat_t0", v0, 0);
        check("lat_t1", v1, 0);
        check("lat_t2", v2, 1);
        check("first_row_val", (last_hs_val == 10'd198 || last_hs_val == 10'd200 || last_hs_val == 10'd202), 1);
        repeat (5) cyc();
        check("single_push", hs_cnt, 1);

        // Held for 20 cycles without ready.
        shift_ready = 1'b0;
        scroll_tick = 1'b1; cyc();
        scroll_tick = 1'b0; cyc();
        cyc();
        held = samp_out;
        stable_err = 0;
        repeat (20) begin
            cyc();
            if (!samp_valid || samp_out != held) stable_err++;
        end
        check("stall_stable", stable_err, 0);
        check("stall_no_hs", hs_cnt, 1);
        shift_ready = 1'b1;
        cyc();
        check("release_hs", hs_cnt, 2);
        check("release_val", last_hs_val, held);
        repeat (3) cyc();

        // Five ticks during a stalled push: three buffered, overflow flagged.
        hs_cnt = 0;
        shift_ready = 1'b0;
        scroll_tick = 1'b1; cyc();
        scroll_tick = 1'b0; cyc();
        cyc();
        for (int k = 0; k < 5; k++) begin
            scroll_tick = 1'b1; cyc();
            scroll_tick = 1'b0; cyc();
            if (k == 2) check("ovf_at_three", tick_overflow, 0);
        end
        check("ovf_set", tick_overflow, 1);
        shift_ready = 1'b1;
        repeat (40) cyc();
        check("backlog_rows", hs_cnt, 4);
        check("ovf_sticky", tick_overflow, 1);

        // Long walk from seed 1.
        seed = 16'h0001; seed_load = 1'b1; cyc();
        seed_load = 1'b0;
        range_err = 0; step_bad = 0; hs_cnt = 0;
        repeat (2000) begin
            scroll_tick = 1'b1; cyc();
            scroll_tick = 1'b0; cyc();
            cyc();
        end
        check("walk_rows", hs_cnt, 2000);
        check("walk_range", range_err, 0);
        check("walk_step", step_bad, 0);
        check("backpressure", bp_err, 0);

        // Asynchronous reset, then again in the middle of preload.
        rst_n = 1'b0;
        #2;
        check("arst_init_done", init_done, 0);
        check("arst_overflow", tick_overflow, 0);
        cyc();
        rst_n = 1'b1;
        hs_cnt = 0; preload_bad = 0;
        for (int i = 0; i < 200 && hs_cnt < 100; i++) cyc();
        check("mid_preload_cnt", hs_cnt, 100);
        rst_n = 1'b0;
        #2;
        check("arst_valid", shift_valid, 0);
        check("arst_init_done2", init_done, 0);
        check("arst_out", boundary_out, 200);
        cyc();
        rst_n = 1'b1;
        hs_cnt = 0;
        for (int i = 0; i < 400 && !init_done; i++) cyc();
        check("repreload_done", init_done, 1);
        check("repreload_count", hs_cnt, 240);
        check("repreload_values", preload_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
